// File: rtl/mcu_pixel_path.sv
// GPU front end: synchronises the asynchronous MCU byte bus, splits command and RGB444 pixel bytes,
// writes pixels into a dual-port framebuffer and generates a programmable clock-enable pulse.
module mcu_pixel_path #(
  parameter int unsigned FB_ADDR_WIDTH = 12,
  parameter int unsigned DIV_WIDTH     = 4
) (
  input  logic                 system_clock,
  input  logic                 reset_n,
  input  logic                 mcu_bus_clock,
  input  logic [7:0]           mcu_bus,
  input  logic                 mcu_bus_command_data,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 divided_clock_enable,
  output logic                 mcu_command_clock,
  output logic [7:0]           command,
  output logic                 mcu_pixel_clock,
  output logic [11:0]          pixel_data,
  output logic [21:0]          write_pointer,
  input  logic [21:0]          framebuffer_read_pointer,
  output logic [11:0]          read_data
);

  localparam int unsigned PTR_WIDTH = 22;
  localparam int unsigned PIX_WIDTH = 12;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned FB_DEPTH  = 2 ** FB_ADDR_WIDTH;
  localparam logic [BYTE_WIDTH-1:0] CMD_RESET_PTR = 8'h01;

  // Bus synchroniser: strobe through two sync stages plus an edge stage; payload delayed alongside.
  logic                  sync1;
  logic                  sync2;
  logic                  edge_ff;
  logic [BYTE_WIDTH-1:0] bus_d1;
  logic [BYTE_WIDTH-1:0] bus_d2;
  logic                  cd_d1;
  logic                  cd_d2;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      edge_ff <= 1'b1;
      bus_d1  <= '0;
      bus_d2  <= '0;
      cd_d1   <= 1'b0;
      cd_d2   <= 1'b0;
    end else begin
      sync1   <= mcu_bus_clock;
      sync2   <= sync1;
      edge_ff <= sync2;
      bus_d1  <= mcu_bus;
      bus_d2  <= bus_d1;
      cd_d1   <= mcu_bus_command_data;
      cd_d2   <= cd_d1;
    end
  end

  logic byte_event_c;
  assign byte_event_c = sync2 & ~edge_ff;

  // Byte decoder: commands, two-byte pixel assembly and write pointer.
  logic                     phase;
  logic [BYTE_WIDTH-1:0]    rg_hold;
  logic [FB_ADDR_WIDTH-1:0] wp;
  logic [PIX_WIDTH-1:0]     pix_c;
  logic                     fb_we_c;

  assign pix_c   = {rg_hold, bus_d2[3:0]};
  assign fb_we_c = reset_n & byte_event_c & ~cd_d2 & phase;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      mcu_command_clock <= 1'b0;
      mcu_pixel_clock   <= 1'b0;
      command           <= '0;
      pixel_data        <= '0;
      wp                <= '0;
      phase             <= 1'b0;
      rg_hold           <= '0;
    end else begin
      mcu_command_clock <= 1'b0;
      mcu_pixel_clock   <= 1'b0;
      if (byte_event_c) begin
        if (cd_d2) begin
          // A command always drops any half-assembled pixel.
          command           <= bus_d2;
          mcu_command_clock <= 1'b1;
          phase             <= 1'b0;
          if (bus_d2 == CMD_RESET_PTR) begin
            wp <= '0;
          end
        end else if (!phase) begin
          rg_hold <= bus_d2;
          phase   <= 1'b1;
        end else begin
          pixel_data      <= pix_c;
          mcu_pixel_clock <= 1'b1;
          wp              <= wp + FB_ADDR_WIDTH'(1);
          phase           <= 1'b0;
        end
      end
    end
  end

  assign write_pointer = PTR_WIDTH'(wp);

  // Framebuffer: synchronous write, registered read; a colliding read returns the old word.
  logic [PIX_WIDTH-1:0] fb_mem [FB_DEPTH];

  always_ff @(posedge system_clock) begin
    if (fb_we_c) begin
      fb_mem[wp] <= pix_c;
    end
  end

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      read_data <= '0;
    end else begin
      read_data <= fb_mem[framebuffer_read_pointer[FB_ADDR_WIDTH-1:0]];
    end
  end

  generate
    if (FB_ADDR_WIDTH < PTR_WIDTH) begin : g_rp_hi
      logic unused_rp_hi;
      assign unused_rp_hi = ^framebuffer_read_pointer[PTR_WIDTH-1:FB_ADDR_WIDTH];
    end
  endgenerate

  // Clock-enable divider; div of 0 or 1 wraps every cycle, a shrinking div wraps immediately.
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH:0]   cnt_inc_c;
  logic                 div_wrap_c;

  assign cnt_inc_c  = {1'b0, div_cnt} + (DIV_WIDTH + 1)'(1);
  assign div_wrap_c = cnt_inc_c >= {1'b0, div};

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      div_cnt              <= '0;
      divided_clock_enable <= 1'b0;
    end else if (div_wrap_c) begin
      div_cnt              <= '0;
      divided_clock_enable <= 1'b1;
    end else begin
      div_cnt              <= cnt_inc_c[DIV_WIDTH-1:0];
      divided_clock_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcu_pixel_path.sv
// Directed bench for mcu_pixel_path: byte strobes are checked against a scoreboard queue,
// framebuffer contents through the read port, and the divider against expected pulse patterns.
module tb_mcu_pixel_path;

  localparam int unsigned FBW   = 12;
  localparam int unsigned DEPTH = 1 << FBW;

  logic        system_clock = 1'b0;
  logic        reset_n;
  logic        mcu_bus_clock;
  logic [7:0]  mcu_bus;
  logic        mcu_bus_command_data;
  logic [3:0]  div;
  logic        divided_clock_enable;
  logic        mcu_command_clock;
  logic [7:0]  command;
  logic        mcu_pixel_clock;
  logic [11:0] pixel_data;
  logic [21:0] write_pointer;
  logic [21:0] framebuffer_read_pointer;
  logic [11:0] read_data;

  mcu_pixel_path #(.FB_ADDR_WIDTH(FBW), .DIV_WIDTH(4)) dut (
    .system_clock             (system_clock),
    .reset_n                  (reset_n),
    .mcu_bus_clock            (mcu_bus_clock),
    .mcu_bus                  (mcu_bus),
    .mcu_bus_command_data     (mcu_bus_command_data),
    .div                      (div),
    .divided_clock_enable     (divided_clock_enable),
    .mcu_command_clock        (mcu_command_clock),
    .command                  (command),
    .mcu_pixel_clock          (mcu_pixel_clock),
    .pixel_data               (pixel_data),
    .write_pointer            (write_pointer),
    .framebuffer_read_pointer (framebuffer_read_pointer),
    .read_data                (read_data)
  );

  always #5 system_clock = ~system_clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int cmd_strobes  = 0;
  int pix_strobes  = 0;
  int last_cmd_cyc = -1;
  logic [11:0] rd_at_pix = '0;

  logic [7:0]  exp_cmd_q [$];
  logic [11:0] exp_pix_q [$];
  logic [21:0] exp_wp_q  [$];

  logic [11:0] model_mem [DEPTH];
  logic        m_phase = 1'b0;
  logic [7:0]  m_rg    = '0;
  int unsigned m_wp    = 0;

  always @(posedge system_clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe pops its expected payload.
  always @(negedge system_clock) begin
    if (reset_n === 1'b1) begin
      if (mcu_command_clock === 1'b1) begin
        cmd_strobes++;
        last_cmd_cyc = cyc;
        if (exp_cmd_q.size() == 0) check("unexpected_cmd_strobe", 32'd1, 32'd0);
        else check("command", 32'(command), 32'(exp_cmd_q.pop_front()));
      end
      if (mcu_pixel_clock === 1'b1) begin
        pix_strobes++;
        rd_at_pix = read_data;
        if (exp_pix_q.size() == 0) check("unexpected_pix_strobe", 32'd1, 32'd0);
        else begin
          check("pixel_data", 32'(pixel_data), 32'(exp_pix_q.pop_front()));
          check("write_pointer", 32'(write_pointer), 32'(exp_wp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic is_cmd, input logic [7:0] b);
    logic [11:0] px;
    if (is_cmd) begin
      exp_cmd_q.push_back(b);
      m_phase = 1'b0;
      if (b == 8'h01) m_wp = 0;
    end else if (!m_phase) begin
      m_rg    = b;
      m_phase = 1'b1;
    end else begin
      px = {m_rg, b[3:0]};
      model_mem[m_wp] = px;
      m_wp = (m_wp + 1) % DEPTH;
      exp_pix_q.push_back(px);
      exp_wp_q.push_back(22'(m_wp));
      m_phase = 1'b0;
    end
    @(negedge system_clock);
    mcu_bus = b;
    mcu_bus_command_data = is_cmd;
    @(negedge system_clock);
    mcu_bus_clock = 1'b1;
    rise_cyc = cyc;
    repeat (2) @(negedge system_clock);
    mcu_bus_clock = 1'b0;
    repeat (2) @(negedge system_clock);
  endtask

  task automatic read_fb(input int unsigned addr, output logic [11:0] val);
    @(negedge system_clock);
    framebuffer_read_pointer = 22'(addr);
    @(negedge system_clock);
    val = read_data;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge system_clock);
      if (divided_clock_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rd;
    logic [11:0] last_px;
    int          c0;
    int          p0;
    bit          ok;
    logic [3:0]  r, g, b, hi;

    reset_n = 1'b0;
    mcu_bus_clock = 1'b1;
    mcu_bus = 8'hFF;
    mcu_bus_command_data = 1'b1;
    div = 4'd3;
    framebuffer_read_pointer = '0;

    // Reset with the bus strobe held high.
    repeat (4) @(negedge system_clock);
    check("rst_enable", 32'(divided_clock_enable), 32'd0);
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_cmd_strobe", 32'(mcu_command_clock), 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge system_clock);
    check("rst_no_strobes", 32'(cmd_strobes + pix_strobes), 32'd0);
    check("rst_command", 32'(command), 32'd0);
    check("rst_pixel_data", 32'(pixel_data), 32'd0);
    check("rst_write_pointer", 32'(write_pointer), 32'd0);
    mcu_bus_clock = 1'b0;
    repeat (3) @(negedge system_clock);

    // Plain command: one-cycle strobe, three cycles after sampling, no write.
    c0 = cmd_strobes;
    p0 = pix_strobes;
    send_byte(1'b1, 8'h02);
    check("cmd02_strobe_count", 32'(cmd_strobes - c0), 32'd1);
    check("cmd02_latency", 32'(last_cmd_cyc - rise_cyc), 32'd3);
    check("cmd02_no_pixel", 32'(pix_strobes - p0), 32'd0);
    check("cmd02_wp", 32'(write_pointer), 32'd0);

    // First pixel.
    send_byte(1'b0, 8'hA5);
    check("half_pixel_no_strobe", 32'(pix_strobes - p0), 32'd0);
    send_byte(1'b0, 8'h3C);
    check("pix_strobe_count", 32'(pix_strobes - p0), 32'd1);
    read_fb(0, rd);
    check("mem0_a5c", 32'(rd), 32'h0A5C);

    // Half pixel discarded by an intervening command.
    send_byte(1'b1, 8'h01);
    check("cmd01_wp_reset", 32'(write_pointer), 32'd0);
    send_byte(1'b0, 8'h12);
    send_byte(1'b1, 8'h07);
    send_byte(1'b0, 8'h34);
    send_byte(1'b0, 8'h56);
    read_fb(0, rd);
    check("mem0_346", 32'(rd), 32'h0346);

    // Read and write of the same address in one cycle returns the old word.
    send_byte(1'b1, 8'h01);
    @(negedge system_clock);
    framebuffer_read_pointer = '0;
    send_byte(1'b0, 8'h77);
    send_byte(1'b0, 8'h89);
    check("collide_old_data", 32'(rd_at_pix), 32'h0346);
    check("collide_new_data", 32'(read_data), 32'h0779);

    // Fill the whole framebuffer plus one pixel so the pointer wraps.
    send_byte(1'b1, 8'h01);
    last_px = '0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      r  = 4'($urandom_range(15));
      g  = 4'($urandom_range(15));
      b  = 4'($urandom_range(15));
      hi = 4'($urandom_range(15));
      send_byte(1'b0, {r, g});
      send_byte(1'b0, {hi, b});
      last_px = {r, g, b};
    end
    check("wrap_wp", 32'(write_pointer), 32'd1);
    read_fb(0, rd);
    check("wrap_mem0_last", 32'(rd), 32'(last_px));
    read_fb(1, rd);
    check("wrap_mem1", 32'(rd), 32'(model_mem[1]));
    read_fb(DEPTH - 1, rd);
    check("wrap_mem_top", 32'(rd), 32'(model_mem[DEPTH - 1]));
    send_byte(1'b1, 8'h01);
    check("wrap_cmd01_wp", 32'(write_pointer), 32'd0);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    check("pix_queue_drained", 32'(exp_pix_q.size()), 32'd0);

    // Divider, ratio 3.
    @(negedge system_clock);
    div = 4'd3;
    repeat (4) @(negedge system_clock);
    wait_pulse(ok);
    check("div3_pulse_seen", 32'(ok), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge system_clock);
      check($sformatf("div3_k%0d", k), 32'(divided_clock_enable), 32'((k % 3) == 0));
    end

    // Ratio 1 gives a constant enable.
    div = 4'd1;
    repeat (2) @(negedge system_clock);
    for (int k = 0; k < 6; k++) begin
      @(negedge system_clock);
      check($sformatf("div1_k%0d", k), 32'(divided_clock_enable), 32'd1);
    end

    // Ratio drops from 5 to 2 while the counter sits at 3.
    div = 4'd5;
    repeat (6) @(negedge system_clock);
    wait_pulse(ok);
    check("div5_pulse_seen", 32'(ok), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge system_clock);
      check($sformatf("div5_k%0d", k), 32'(divided_clock_enable), 32'd0);
    end
    div = 4'd2;
    for (int k = 4; k <= 8; k++) begin
      @(negedge system_clock);
      check($sformatf("div5to2_k%0d", k), 32'(divided_clock_enable), 32'((k % 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
